// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle for pipe_skid_reg: upstream valid/ready/data, downstream valid/ready/data, occupancy.
// master = the environment driving the stage, slave = the stage itself.
interface pipe_skid_reg_if #(
    parameter int n = 32
);
    logic [n-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [n-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   count;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, count
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, count
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// Two-slot skid pipeline register with fully registered valid/ready/count outputs.
// Optional synchronous flush port is built when PIPE_FLUSH_EN is defined.
module pipe_skid_reg #(
    parameter int n = 32
) (
    input  logic clk,
    input  logic rst,
`ifdef PIPE_FLUSH_EN
    input  logic flush,
`endif
    pipe_skid_reg_if.slave bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t       state_reg;
    logic [n-1:0] main_reg;
    logic [n-1:0] skid_reg;
    logic [1:0]   count_reg;
    logic         in_ready_reg;
    logic         out_valid_reg;

    logic in_acc;
    logic out_acc;

    // Handshake outputs are registered alongside the state, so ready never
    // depends combinationally on out_ready or in_valid.
    assign in_acc  = bus.in_valid & in_ready_reg;
    assign out_acc = out_valid_reg & bus.out_ready;

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = main_reg;
    assign bus.count     = count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= EMPTY;
            main_reg      <= '0;
            skid_reg      <= '0;
            count_reg     <= 2'd0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end
`ifdef PIPE_FLUSH_EN
        else if (flush) begin
            state_reg     <= EMPTY;
            count_reg     <= 2'd0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end
`endif
        else begin
            case (state_reg)
                EMPTY: begin
                    if (in_acc) begin
                        main_reg      <= bus.in_data;
                        state_reg     <= ONE;
                        count_reg     <= 2'd1;
                        in_ready_reg  <= 1'b1;
                        out_valid_reg <= 1'b1;
                    end
                end
                ONE: begin
                    if (in_acc && out_acc) begin
                        main_reg <= bus.in_data;
                    end else if (in_acc) begin
                        // Downstream stalled: park the new payload behind main.
                        skid_reg      <= bus.in_data;
                        state_reg     <= FULL;
                        count_reg     <= 2'd2;
                        in_ready_reg  <= 1'b0;
                        out_valid_reg <= 1'b1;
                    end else if (out_acc) begin
                        state_reg     <= EMPTY;
                        count_reg     <= 2'd0;
                        in_ready_reg  <= 1'b1;
                        out_valid_reg <= 1'b0;
                    end
                end
                FULL: begin
                    if (out_acc) begin
                        main_reg      <= skid_reg;
                        state_reg     <= ONE;
                        count_reg     <= 2'd1;
                        in_ready_reg  <= 1'b1;
                        out_valid_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= EMPTY;
                    count_reg     <= 2'd0;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed vector table plus corner-case sequences and a randomized scoreboard run for pipe_skid_reg.
// Build with +define+PIPE_FLUSH_EN to also exercise the flush path.
module tb_pipe_skid_reg;

    logic clk = 1'b0;
    logic rst = 1'b0;
`ifdef PIPE_FLUSH_EN
    logic flush = 1'b0;
`endif

    always #5 clk = ~clk;

    pipe_skid_reg_if #(.n(8)) bus ();

    pipe_skid_reg #(.n(8)) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef PIPE_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus.slave)
    );

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       ov;
        logic [7:0] od;
        logic       ir;
        logic [1:0] cnt;
    } vec_t;

    vec_t vecs [15];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] q [$];
    logic [7:0] held;
    logic       hold_pending;
    int         sent;
    int         got;
    int         cyc;

    initial begin
        // REQ-028 stream, REQ-029 backpressure fill/drain, REQ-030 FULL with simultaneous offer
        vecs[0]  = '{1'b1, 8'h11, 1'b1, 1'b1, 8'h11, 1'b1, 2'd1};
        vecs[1]  = '{1'b1, 8'h22, 1'b1, 1'b1, 8'h22, 1'b1, 2'd1};
        vecs[2]  = '{1'b1, 8'h33, 1'b1, 1'b1, 8'h33, 1'b1, 2'd1};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h33, 1'b1, 2'd0};
        vecs[4]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 8'hA1, 1'b1, 2'd1};
        vecs[5]  = '{1'b1, 8'hA2, 1'b0, 1'b1, 8'hA1, 1'b0, 2'd2};
        vecs[6]  = '{1'b1, 8'hA3, 1'b0, 1'b1, 8'hA1, 1'b0, 2'd2};
        vecs[7]  = '{1'b1, 8'hA3, 1'b1, 1'b1, 8'hA2, 1'b1, 2'd1};
        vecs[8]  = '{1'b1, 8'hA3, 1'b1, 1'b1, 8'hA3, 1'b1, 2'd1};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA3, 1'b1, 2'd0};
        vecs[10] = '{1'b1, 8'hB1, 1'b0, 1'b1, 8'hB1, 1'b1, 2'd1};
        vecs[11] = '{1'b1, 8'hB2, 1'b0, 1'b1, 8'hB1, 1'b0, 2'd2};
        vecs[12] = '{1'b1, 8'hB3, 1'b1, 1'b1, 8'hB2, 1'b1, 2'd1};
        vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hB2, 1'b1, 2'd1};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hB2, 1'b1, 2'd0};

        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_count", bus.count, 2'd0);
        check("reset_out_valid", bus.out_valid, 1'b0);
        check("reset_out_data", bus.out_data, 8'h00);
        check("reset_in_ready", bus.in_ready, 1'b1);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            bus.in_valid  = vecs[i].iv;
            bus.in_data   = vecs[i].d;
            bus.out_ready = vecs[i].ordy;
            tick();
            $display("vec %0d: iv=%0b d=%0h ordy=%0b -> ov=%0b od=%0h ir=%0b cnt=%0d",
                     i, vecs[i].iv, vecs[i].d, vecs[i].ordy,
                     bus.out_valid, bus.out_data, bus.in_ready, bus.count);
            check($sformatf("vec%0d_out_valid", i), bus.out_valid, vecs[i].ov);
            check($sformatf("vec%0d_out_data", i), bus.out_data, vecs[i].od);
            check($sformatf("vec%0d_in_ready", i), bus.in_ready, vecs[i].ir);
            check($sformatf("vec%0d_count", i), bus.count, vecs[i].cnt);
        end

        // Asynchronous reset while FULL takes effect without a clock edge.
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hD1;
        bus.out_ready = 1'b0;
        tick();
        bus.in_data = 8'hD2;
        tick();
        check("pre_reset_count", bus.count, 2'd2);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        $display("async reset: ov=%0b od=%0h ir=%0b cnt=%0d", bus.out_valid, bus.out_data, bus.in_ready, bus.count);
        check("async_rst_out_valid", bus.out_valid, 1'b0);
        check("async_rst_count", bus.count, 2'd0);
        check("async_rst_out_data", bus.out_data, 8'h00);
        check("async_rst_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hE1;
        tick();
        $display("post reset load: ov=%0b od=%0h cnt=%0d", bus.out_valid, bus.out_data, bus.count);
        check("post_rst_out_valid", bus.out_valid, 1'b1);
        check("post_rst_out_data", bus.out_data, 8'hE1);
        check("post_rst_count", bus.count, 2'd1);

`ifdef PIPE_FLUSH_EN
        bus.in_data = 8'hC2;
        tick();
        check("pre_flush_count", bus.count, 2'd2);
        flush         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hC5;
        bus.out_ready = 1'b1;
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        $display("flush: ov=%0b od=%0h ir=%0b cnt=%0d", bus.out_valid, bus.out_data, bus.in_ready, bus.count);
        check("flush_count", bus.count, 2'd0);
        check("flush_out_valid", bus.out_valid, 1'b0);
        check("flush_in_ready", bus.in_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flush_stays_empty", bus.out_valid, 1'b0);
            check("flush_no_c5", bus.out_data == 8'hC5, 1'b0);
        end
`endif

        // Drain to EMPTY, then run the randomized scoreboard.
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("drain_count", bus.count, 2'd0);

        sent = 0;
        got = 0;
        cyc = 0;
        hold_pending = 1'b0;
        held = 8'h00;
        while (got < 1000 && cyc < 20000) begin
            bus.in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            bus.in_data   = 8'($urandom_range(0, 255));
            bus.out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            check("rand_count", bus.count, q.size());
            check("rand_out_valid", bus.out_valid, q.size() != 0);
            if (hold_pending)
                check("rand_stable", bus.out_data, held);
            if (bus.out_valid && bus.out_ready && q.size() != 0) begin
                check("rand_order", bus.out_data, q[0]);
                $display("rand out %0d: data=%0h expected=%0h", got, bus.out_data, q[0]);
                void'(q.pop_front());
                got++;
            end
            hold_pending = bus.out_valid && !bus.out_ready;
            held = bus.out_data;
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(bus.in_data);
                sent++;
            end
            cyc++;
            tick();
        end
        if (got < 1000) begin
            n_checks++;
            n_errors++;
            $display("FAIL rand_timeout: got %0d payloads expected 1000", got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The block SHALL have parameter n, default 32: width of the data payload carried between stages.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous reset, active-low.
REQ-004 The block SHALL have port in_data  input  n  upstream payload.
REQ-005 The block SHALL have port in_valid  input  1  upstream payload valid.
REQ-006 The block SHALL have port in_ready  output  1  block can accept a payload this cycle.
REQ-007 The block SHALL have port out_data  output  n  payload presented to the downstream stage (operand mux inputs).
REQ-008 The block SHALL have port out_valid  output  1  out_data holds a valid payload.
REQ-009 The block SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-010 The block SHALL have port count  output  2  occupancy: 0, 1 or 2 stored payloads.
REQ-011 The block SHALL have port flush  input  1  synchronous discard of all stored payloads; present only when PIPE_FLUSH_EN is defined.

Function
REQ-012 The block SHALL hold two storage slots, main (drives out_data) and skid, tracked by a three-state FSM: EMPTY (count=0), ONE (count=1), FULL (count=2).
REQ-013 Transfers SHALL occur only on rising clk edges where valid and ready are both 1 on the same side: in-accept = in_valid & in_ready; out-accept = out_valid & out_ready.
REQ-014 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL, decoded from state only, with no combinational path from out_ready or in_valid.
REQ-015 out_valid SHALL be 1 in ONE and FULL and 0 in EMPTY; out_data SHALL be the main slot.
REQ-016 EMPTY: in-accept -> main<=in_data, go ONE; otherwise stay EMPTY.
REQ-017 ONE: in-accept and out-accept -> main<=in_data, stay ONE; in-accept only -> skid<=in_data, go FULL; out-accept only -> go EMPTY; neither -> hold.
REQ-018 FULL: out-accept -> main<=skid, go ONE; otherwise hold; no input is accepted.
REQ-019 Latency SHALL be exactly one cycle from in-accept into EMPTY to out_valid=1; sustained throughput SHALL be one payload per cycle while out_ready=1.
REQ-020 Payload order SHALL be strictly FIFO; no payload is dropped or duplicated except by flush.
REQ-021 While out_valid=1 and out_ready=0, out_data SHALL remain stable until out-accept.
REQ-022 The skid slot content SHALL be don't-care outside FULL; main content SHALL be don't-care in EMPTY, but out_data SHALL not change in EMPTY unless loaded.
REQ-023 count SHALL equal the FSM occupancy in the same cycle, never reaching 3.

Reset
REQ-024 On rst=0, the block SHALL go to EMPTY immediately: count=0, out_valid=0, out_data=0, skid=0, in_ready=1.
REQ-025 A payload in flight when reset asserts SHALL be lost; the first edge after rst returns to 1 behaves as REQ-016.

Configuration
REQ-026 With macro PIPE_FLUSH_EN defined, flush=1 at a clock edge SHALL force EMPTY and count=0, overriding any simultaneous in-accept or out-accept; the input offered that cycle is discarded.
REQ-027 With PIPE_FLUSH_EN undefined, the flush port SHALL not exist and behaviour SHALL be exactly REQ-012..REQ-025.

Verification
REQ-028 n=8; after reset, in_valid=1 with data 0x11,0x22,0x33 on consecutive edges, out_ready=1 -> out_data 0x11,0x22,0x33 one cycle later each, count stays 1, in_ready stays 1.
REQ-029 out_ready=0, offer 0xA1 then 0xA2 then 0xA3 -> count 1 then 2, in_ready=0 after 0xA2, 0xA3 held upstream; out_ready=1 -> outputs 0xA1,0xA2,0xA3 in order.
REQ-030 FULL with 0xB1/0xB2, out_ready=1 and in_valid=1 (0xB3) same cycle -> 0xB1 leaves, main=0xB2, 0xB3 not accepted (in_ready=0), count=1.
REQ-031 rst=0 asserted mid-cycle while FULL -> out_valid=0, count=0, out_data=0, in_ready=1 without waiting for a clock edge.
REQ-032 PIPE_FLUSH_EN defined, FULL, flush=1 with in_valid=1 (0xC5) -> next cycle count=0, out_valid=0; 0xC5 never appears at out_data.
REQ-033 Random in_valid/out_ready, 1000 payloads -> scoreboard shows in-order, lossless delivery and out_data stable under backpressure.
